// File: rtl/seq_booth_divider.sv
// seq_booth_divider: sequential signed restoring divider, one quotient bit per clock.
// Optional quotient-range overflow detection is built when DIV_OVF_DETECT_EN is defined.
module seq_booth_divider #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               dz,
    output logic               ovf
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(W2 + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state;
    logic              sq;
    logic              sr;
    logic [W2-1:0]     qr;
    logic [WIDTH-1:0]  pr;
    logic [WIDTH-1:0]  dm;
    logic [CW-1:0]     cnt;
    logic [W2-1:0]     dvd_mag;
    logic [WIDTH-1:0]  dvs_mag;
    logic [WIDTH:0]    sh;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  q_s;
    logic [WIDTH-1:0]  r_s;

    // pr stays below the divisor magnitude, so only the shifted value needs the extra bit
    always_comb begin
        dvd_mag = dividend[W2-1] ? -dividend : dividend;
        dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
        sh      = {pr, qr[W2-1]};
        diff    = sh - {1'b0, dm};
        q_s     = sq ? -qr[WIDTH-1:0] : qr[WIDTH-1:0];
        r_s     = sr ? -pr : pr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (divisor == '0) begin
                        done      <= 1'b1;
                        dz        <= 1'b1;
                        quotient  <= '1;
                        remainder <= dividend[WIDTH-1:0];
                    end else begin
                        sq    <= dividend[W2-1] ^ divisor[WIDTH-1];
                        sr    <= dividend[W2-1];
                        qr    <= dvd_mag;
                        pr    <= '0;
                        dm    <= dvs_mag;
                        cnt   <= CW'(W2);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    qr    <= {qr[W2-2:0], ~diff[WIDTH]};
                    pr    <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == CW'(1)) ? FIX : CALC;
                end
                FIX: begin
                    quotient  <= q_s;
                    remainder <= r_s;
                    dz        <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIV_OVF_DETECT_EN
    logic ovf_n;
    assign ovf_n = sq ? (qr > (W2'(1) << (WIDTH - 1))) : (qr > ((W2'(1) << (WIDTH - 1)) - 1'b1));

    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (state == IDLE && start && divisor == '0)
            ovf <= 1'b0;
        else if (state == FIX)
            ovf <= ovf_n;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_booth_divider.sv
// tb_seq_booth_divider: scoreboard bench for seq_booth_divider at WIDTH=4.
// Expected ovf follows DIV_OVF_DETECT_EN.
module tb_seq_booth_divider;
`ifdef DIV_OVF_DETECT_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ovf;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       dz;
    logic       ovf;

    int   total = 0;
    int   bad = 0;
    int   ndone = 0;
    exp_t sbq[$];

    seq_booth_divider #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            ndone++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want no pending result q=%0h r=%0h", quotient, remainder);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.nm, "_q"}, 32'(quotient), 32'(e.q));
                chk({e.nm, "_r"}, 32'(remainder), 32'(e.r));
                chk({e.nm, "_dz"}, 32'(dz), 32'(e.dz));
                chk({e.nm, "_ovf"}, 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    endtask

    task automatic wait_done(input string nm, input int n0);
        for (int i = 0; i < 20 && ndone == n0; i++) begin
            @(negedge clk);
            #1;
        end
        if (ndone == n0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done want done within 20 cycles", nm);
        end
    endtask

    task automatic do_div(input logic [7:0] dvd, input logic [3:0] dvs, input logic [3:0] eq,
                          input logic [3:0] er, input logic edz, input logic eovf, input string nm);
        int n0;
        @(negedge clk);
        wait_idle();
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        sbq.push_back('{eq, er, edz, eovf, nm});
        n0 = ndone;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(nm, n0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        chk("rst_dz", 32'(dz), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;

        // -49 / -7: busy after edges k..k+8, done after edge k+9
        @(negedge clk);
        dividend = 8'hCF;
        divisor  = 4'h9;
        start    = 1'b1;
        sbq.push_back('{4'h7, 4'h0, 1'b0, 1'b0, "m49_m7"});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            chk($sformatf("lat_busy%0d", i), 32'(busy), 32'(i < 9));
            chk($sformatf("lat_done%0d", i), 32'(done), 32'(i == 9));
        end
        @(posedge clk);
        #1;
        chk("lat_done_pulse", 32'(done), 0);

        do_div(8'd50, 4'd7, 4'h7, 4'h1, 1'b0, 1'b0, "p50_p7");
        do_div(8'hCE, 4'd7, 4'h9, 4'hF, 1'b0, 1'b0, "m50_p7");
        do_div(8'hC8, 4'd7, 4'h8, 4'h0, 1'b0, 1'b0, "m56_p7");
        do_div(8'd56, 4'd7, 4'h8, 4'h0, 1'b0, OVF, "p56_p7");
        do_div(8'h80, 4'd1, 4'h0, 4'h0, 1'b0, OVF, "m128_p1");
        do_div(8'h7F, 4'h8, 4'h1, 4'h7, 1'b0, OVF, "p127_m8");
        do_div(8'hFF, 4'd2, 4'h0, 4'hF, 1'b0, 1'b0, "m1_p2");

        // divide by zero completes on the accepting edge without busy
        @(negedge clk);
        dividend = 8'd20;
        divisor  = 4'd0;
        start    = 1'b1;
        sbq.push_back('{4'hF, 4'h4, 1'b1, 1'b0, "dz20"});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("dz_busy", 32'(busy), 0);
        chk("dz_done", 32'(done), 1);
        @(posedge clk);
        #1;
        chk("dz_busy2", 32'(busy), 0);
        chk("dz_done2", 32'(done), 0);

        // sweep: (A*B) / B recovers A
        for (int a = -7; a <= 7; a++)
            for (int b = -7; b <= 7; b++)
                if (b != 0)
                    do_div(8'(a * b), 4'(b), 4'(a), 4'h0, 1'b0, 1'b0, $sformatf("sw_%0d_%0d", a, b));

        // start while busy is ignored
        begin
            int n0;
            @(negedge clk);
            wait_idle();
            dividend = 8'd50;
            divisor  = 4'd7;
            start    = 1'b1;
            sbq.push_back('{4'h7, 4'h1, 1'b0, 1'b0, "ign_first"});
            n0 = ndone;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            dividend = 8'h10;
            divisor  = 4'h3;
            start    = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_done("ign_first", n0);
            repeat (12) @(negedge clk);
            chk("ign_ndone", 32'(ndone - n0), 1);
        end

        // start held through done: back-to-back, operands change after acceptance
        begin
            int n0;
            @(negedge clk);
            wait_idle();
            dividend = 8'hC8;
            divisor  = 4'd7;
            start    = 1'b1;
            sbq.push_back('{4'h8, 4'h0, 1'b0, 1'b0, "b2b_first"});
            n0 = ndone;
            @(posedge clk);
            #1;
            dividend = 8'd56;
            divisor  = 4'd7;
            sbq.push_back('{4'h8, 4'h0, 1'b0, OVF, "b2b_second"});
            for (int i = 0; i < 20 && !done; i++) begin
                @(posedge clk);
                #1;
            end
            chk("b2b_first_seen", 32'(ndone - n0 + 32'(done)), 1);
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("b2b_accept_busy", 32'(busy), 1);
            for (int i = 1; i <= 9; i++) begin
                @(posedge clk);
                #1;
                chk($sformatf("b2b_done%0d", i), 32'(done), 32'(i == 9));
            end
            @(negedge clk);
        end

        // reset in CALC step 3 aborts with no done
        begin
            int n0;
            @(negedge clk);
            wait_idle();
            dividend = 8'd50;
            divisor  = 4'd7;
            start    = 1'b1;
            n0 = ndone;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("abort_busy", 32'(busy), 0);
            chk("abort_done", 32'(done), 0);
            chk("abort_q", 32'(quotient), 0);
            chk("abort_r", 32'(remainder), 0);
            chk("abort_dz", 32'(dz), 0);
            chk("abort_ovf", 32'(ovf), 0);
            rst = 1'b0;
            repeat (15) @(negedge clk);
            chk("abort_no_done", 32'(ndone - n0), 0);
        end

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1000000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_booth_divider.md
Name: seq_booth_divider

Overview:
- Sequential signed divider, the inverse operation of the combinational 4x4 Booth multiplier block.
- Takes a 2*WIDTH-bit signed dividend (a product-width value) and a WIDTH-bit signed divisor. Returns a WIDTH-bit signed quotient and remainder.
- Restoring magnitude division, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic test suite; feeding `mul` and `B` back in must recover `A`.

Parameters:
- WIDTH, 4, operand width; dividend is 2*WIDTH bits. Legal range 2..16.

Ports:
- clk        input   1          rising-edge clock
- rst        input   1          reset; synchronous to clk, active-high
- start      input   1          request; sampled only when idle
- dividend   input   2*WIDTH    signed dividend, captured on the accepting edge
- divisor    input   WIDTH      signed divisor, captured on the accepting edge
- busy       output  1          division in progress
- done       output  1          one-cycle pulse; results valid
- quotient   output  WIDTH      signed quotient
- remainder  output  WIDTH      signed remainder
- dz         output  1          divide-by-zero flag for the latest result
- ovf        output  1          quotient-overflow flag for the latest result (see Optional Feature)

Behaviour:
- Reset: on a rising edge with rst=1, state goes to IDLE. busy=0, done=0, quotient=0, remainder=0, dz=0, ovf=0. Reset wins over every other event, including mid-division; the aborted operation produces no done.
- States: IDLE, CALC, FIX.
- IDLE, start=1, divisor!=0 (edge k):
  - Capture operand signs.
  - Load the magnitude of the dividend (2W bits) into the quotient shift register and clear a (WIDTH+1)-bit partial remainder.
  - Load the divisor magnitude. Iteration counter = 2*WIDTH.
  - Go to CALC; busy=1.
- IDLE, start=1, divisor==0 (edge k):
  - Stay in IDLE. At edge k, done=1, dz=1, ovf=0.
  - quotient = all ones; remainder = dividend[WIDTH-1:0].
  - busy never asserts.
- CALC: each edge performs one step:
  - Shift {partial remainder, quotient register} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set quotient LSB=1; else restore and set LSB=0.
  - Decrement the counter. After 2*WIDTH steps (edges k+1..k+2W), go to FIX.
- FIX (edge k+2W+1):
  - Negate the quotient if the operand signs differ. Give the remainder the dividend's sign (truncation toward zero; dividend = q*divisor + r).
  - Register the outputs. done=1 for exactly this one cycle; busy=0; state goes to IDLE.
- Latency: done is high after edge k+2*WIDTH+1 (9 edges for WIDTH=4).
- Handshake rules:
  - start while busy=1 is ignored; operands are not re-sampled.
  - start asserted in the cycle where done=1 is accepted, allowing back-to-back operation.
  - Operand inputs may change freely after the accepting edge.
- Output hold: quotient, remainder, dz and ovf hold their values until the next done or reset. done is 0 in all other cycles.
- Width rules:
  - Magnitude of the most negative dividend (-2^(2W-1)) must be handled; use a 2W-bit unsigned magnitude.
  - The remainder magnitude is less than the divisor magnitude, so it always fits in WIDTH signed bits.
  - quotient outputs the low WIDTH bits of the signed true quotient.

Optional Feature:
- Macro: DIV_OVF_DETECT_EN.
- Defined: at FIX, ovf=1 when the true signed quotient lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. quotient still carries the truncated low bits.
- Undefined: ovf is held at constant 0 and no range-check logic is built.
- dz behaviour is identical in both builds.

Test Plan (WIDTH=4):
- Reset, then dividend=-49, divisor=-7, start for 1 cycle -> busy=1 for edges k..k+8; done pulses once after edge k+9 with quotient=7, remainder=0, dz=0, ovf=0.
- dividend=50, divisor=7 -> quotient=7, remainder=1. dividend=-50, divisor=7 -> quotient=-7, remainder=-1. dividend=-56, divisor=7 -> quotient=-8, remainder=0, ovf=0.
- dividend=56, divisor=7 -> quotient=4'h8, remainder=0. ovf=1 with DIV_OVF_DETECT_EN defined, ovf=0 without it. Exhaustive sweep: for every A,B in -7..7, dividing the multiplier's `mul` output by B (B!=0) returns A with remainder 0.
- dividend=20, divisor=0 -> done after the accepting edge with dz=1, quotient=4'hF, remainder=4'h4, busy never high.
- start pulsed again while busy with different operands -> ignored, first result unchanged. start held high through the done cycle -> second division starts immediately, done 9 edges later.
- rst asserted at CALC step 3 -> next cycle busy=0, done=0, all outputs 0; no done ever follows for the aborted operation.
